// File: rtl/text_lcd_sink.sv
// ---------------------------------------------------------------------------
// text_lcd_sink
// Controller end of an 8-bit HD44780-style character LCD bus. Samples the
// bus, decodes instructions and data writes, and mirrors a 2x16 character
// buffer plus mode registers so the panel contents can be read on-chip.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   lcd_enb         bus enable E; a transfer is taken on its falling edge
//   lcd_rs          0 = instruction, 1 = data
//   lcd_rw          0 = write, 1 = read (read transfers are ignored)
//   lcd_data[7:0]   instruction / character code
//   rd_addr[4:0]    buffer read index {line, column}
//   rd_char[7:0]    registered buffer byte at rd_addr (1-cycle latency)
//   ac[6:0]         DDRAM address counter
//   disp_on, cursor_on, blink_on, incr, two_line   mode registers
//   init_done       sticky, set by the first function set
//   busy            instruction in execution, transfers dropped
//   ovr             sticky, a write transfer arrived while busy
//   frame_upd       1-cycle pulse on a stored data write or clear completion
// ---------------------------------------------------------------------------
module text_lcd_sink #(
  parameter int CMD_CYC = 40,
  parameter int CLR_CYC = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enb,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic       two_line,
  output logic       init_done,
  output logic       busy,
  output logic       ovr,
  output logic       frame_upd
);

  localparam int CMAX = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  // E synchroniser with one extra stage for edge detection:
  // [0],[1] are the two sync FFs, [2] is the previous synced value.
  logic [2:0]  enb_pipe_q;
  // {rw, rs, data} through two sync FFs, aligned with enb_pipe_q[1]
  logic [9:0]  bus_s1_q, bus_s2_q;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      clr_idx_q, clr_idx_d;
  logic [6:0]      ac_q, ac_d;
  logic            disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
  logic            incr_q, incr_d, two_q, two_d, init_q, init_d;
  logic            ovr_q, ovr_d, fu_q, fu_d;

  logic [31:0][7:0] mem_q;
  logic [7:0]       rd_char_q;

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_val;

  logic        fall, s_rw, s_rs, wr_xfer;
  logic [7:0]  s_data;

  assign fall    = enb_pipe_q[2] & ~enb_pipe_q[1];
  assign s_rw    = bus_s2_q[9];
  assign s_rs    = bus_s2_q[8];
  assign s_data  = bus_s2_q[7:0];
  assign wr_xfer = fall & ~s_rw;

  // Address counter step. Two-line mode skips the hidden gaps between the
  // visible line windows; one-line mode wraps the 80-byte space.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                         input logic two);
    logic [6:0] r;
    if (two) begin
      if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else     r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    end else begin
      if (inc) r = (a == 7'h4F) ? 7'h00 : a + 7'd1;
      else     r = (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
    return r;
  endfunction

  // ---------------- input synchronisers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enb_pipe_q <= '0;
      bus_s1_q   <= '0;
      bus_s2_q   <= '0;
    end else begin
      enb_pipe_q <= {enb_pipe_q[1:0], lcd_enb};
      bus_s1_q   <= {lcd_rw, lcd_rs, lcd_data};
      bus_s2_q   <= bus_s1_q;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_idx_q <= '0;
      ac_q      <= '0;
      disp_q    <= 1'b0;
      curs_q    <= 1'b0;
      blink_q   <= 1'b0;
      incr_q    <= 1'b1;
      two_q     <= 1'b0;
      init_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fu_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      ac_q      <= ac_d;
      disp_q    <= disp_d;
      curs_q    <= curs_d;
      blink_q   <= blink_d;
      incr_q    <= incr_d;
      two_q     <= two_d;
      init_q    <= init_d;
      ovr_q     <= ovr_d;
      fu_q      <= fu_d;
    end
  end

  // ---------------- next state / decode ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    ac_d      = ac_q;
    disp_d    = disp_q;
    curs_d    = curs_q;
    blink_d   = blink_q;
    incr_d    = incr_q;
    two_d     = two_q;
    init_d    = init_q;
    ovr_d     = ovr_q;
    fu_d      = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_val    = 8'h20;

    unique case (state_q)
      IDLE: begin
        if (wr_xfer) begin
          state_d = EXEC;
          cnt_d   = CW'(CMD_CYC);
          if (s_rs) begin
            // only the two visible 16-char windows are backed by storage
            if (ac_q[6:4] == 3'b000 || ac_q[6:4] == 3'b100) begin
              wr_en  = 1'b1;
              wr_idx = {ac_q[6], ac_q[3:0]};
              wr_val = s_data;
              fu_d   = 1'b1;
            end
            ac_d = ac_step(ac_q, incr_q, two_q);
          end else begin
            if (s_data[7])      ac_d = s_data[6:0];
            else if (s_data[6]) ;  // CGRAM address: accepted, no effect
            else if (s_data[5]) begin
              two_d  = s_data[3];
              init_d = 1'b1;
            end
            else if (s_data[4]) ;  // cursor/display shift: no effect
            else if (s_data[3]) begin
              disp_d  = s_data[2];
              curs_d  = s_data[1];
              blink_d = s_data[0];
            end
            else if (s_data[2]) incr_d = s_data[1];
            else if (s_data[1]) ac_d = '0;
            else if (s_data[0]) begin
              state_d   = CLEAR;
              cnt_d     = CW'(CLR_CYC);
              clr_idx_d = '0;
              ac_d      = '0;
              incr_d    = 1'b1;
            end
          end
        end
      end
      EXEC: begin
        if (wr_xfer) ovr_d = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      CLEAR: begin
        if (wr_xfer) ovr_d = 1'b1;
        // sweep blanks through the buffer; CLR_CYC >= 32 so it always finishes
        if (!clr_idx_q[5]) begin
          wr_en     = 1'b1;
          wr_idx    = clr_idx_q[4:0];
          clr_idx_d = clr_idx_q + 6'd1;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          fu_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- character buffer ----------------
  // Read samples mem_q before this cycle's write lands, so a same-index
  // read returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
      rd_char_q <= 8'h20;
    end else begin
      rd_char_q <= mem_q[rd_addr];
      if (wr_en) mem_q[wr_idx] <= wr_val;
    end
  end

  assign rd_char   = rd_char_q;
  assign ac        = ac_q;
  assign disp_on   = disp_q;
  assign cursor_on = curs_q;
  assign blink_on  = blink_q;
  assign incr      = incr_q;
  assign two_line  = two_q;
  assign init_done = init_q;
  assign busy      = (state_q != IDLE);
  assign ovr       = ovr_q;
  assign frame_upd = fu_q;

endmodule

// File: tb/tb_text_lcd_sink.sv
module tb_text_lcd_sink;
  localparam int CMD_CYC = 40;
  localparam int CLR_CYC = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_enb = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, incr, two_line, init_done;
  logic       busy, ovr, frame_upd;

  text_lcd_sink #(.CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst), .lcd_enb(lcd_enb), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .incr(incr),
    .two_line(two_line), .init_done(init_done), .busy(busy), .ovr(ovr),
    .frame_upd(frame_upd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // panel model
  logic [7:0] mem [32];
  logic [6:0] m_ac;
  logic       m_incr, m_two;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] a);
    if (m_two) begin
      if (m_incr) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : 7'(a + 1);
      return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : 7'(a - 1);
    end
    if (m_incr) return (a == 7'h4F) ? 7'h00 : 7'(a + 1);
    return (a == 7'h00) ? 7'h4F : 7'(a - 1);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    m_ac = 0; m_incr = 1; m_two = 0;
  endtask

  // applies one accepted write to the model; reports stored / clear
  task automatic m_apply(input logic rs, input logic [7:0] d,
                         output bit stored, output bit is_clr);
    stored = 0; is_clr = 0;
    if (rs) begin
      if (m_ac <= 7'h0F) begin mem[m_ac[3:0]] = d; stored = 1; end
      else if (m_ac >= 7'h40 && m_ac <= 7'h4F) begin mem[16 + m_ac[3:0]] = d; stored = 1; end
      m_ac = m_step(m_ac);
    end else if (d[7]) m_ac = d[6:0];
    else if (d[6]) ;
    else if (d[5]) m_two = d[3];
    else if (d[4] || d[3]) ;
    else if (d[2]) m_incr = d[1];
    else if (d[1]) m_ac = 0;
    else if (d[0]) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
      m_ac = 0; m_incr = 1; is_clr = 1;
    end
  endtask

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_enb = 1'b1;
    repeat (4) @(negedge clk);
    lcd_enb = 1'b0;
  endtask

  // drive a transfer and watch busy/frame_upd until it completes
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      output int bcnt, output int fcnt);
    bit seen;
    bcnt = 0; fcnt = 0; seen = 0;
    pulse(rs, rw, d);
    for (int i = 0; i < CLR_CYC + 50; i++) begin
      @(negedge clk);
      if (busy) begin bcnt++; seen = 1; end
      if (frame_upd) fcnt++;
      if (seen && !busy) break;
      if (!seen && i >= 8) break;
    end
  endtask

  task automatic lcd_wr(input logic rs, input logic [7:0] d);
    int bc, fc; bit st, cl;
    m_apply(rs, d, st, cl);
    xfer(rs, 1'b0, d, bc, fc);
    chk($sformatf("busy_len_%0d_%02h", rs, d), bc, cl ? CLR_CYC : CMD_CYC);
    chk($sformatf("frame_upd_%0d_%02h", rs, d), fc, (st || cl) ? 1 : 0);
    chk($sformatf("ac_%0d_%02h", rs, d), ac, m_ac);
  endtask

  task automatic rd_chk(input int idx);
    @(negedge clk);
    rd_addr = 5'(idx);
    sb_q.push_back(mem[idx]);
    @(negedge clk);
    if (sb_q.size() == 0) chk("sb_empty", 0, 1);
    else chk($sformatf("rd_char[%0d]", idx), rd_char, sb_q.pop_front());
  endtask

  task automatic rd_all();
    for (int i = 0; i < 32; i++) rd_chk(i);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    bit hit = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy === lvl) begin hit = 1; break; end
    end
    if (!hit) chk(tag, 0, 1);
  endtask

  initial begin
    int bc, fc;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("rst_rd_char", rd_char, 8'h20);
    chk("rst_ac", ac, 0);
    chk("rst_incr", incr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_init", init_done, 0);
    rd_all();

    // 2: basic init and two characters
    lcd_wr(0, 8'h3C); lcd_wr(0, 8'h0C); lcd_wr(0, 8'h06); lcd_wr(0, 8'h80);
    lcd_wr(1, 8'h48); lcd_wr(1, 8'h69);
    chk("t2_idx0", mem[0], 8'h48);
    rd_chk(0); rd_chk(1);
    chk("t2_ac", ac, 7'h02);
    chk("t2_disp", disp_on, 1);
    chk("t2_cursor", cursor_on, 0);
    chk("t2_two", two_line, 1);
    chk("t2_init", init_done, 1);

    // read transfer: no effect, no busy
    xfer(1, 1, 8'h55, bc, fc);
    chk("rw_busy", bc, 0);
    chk("rw_ac", ac, 7'h02);
    lcd_wr(0, 8'h0F);
    chk("disp_all", {disp_on, cursor_on, blink_on}, 3'b111);

    // 3: end of line 2 window, then hidden area
    lcd_wr(0, 8'hCF); lcd_wr(1, 8'h41); lcd_wr(1, 8'h42);
    chk("t3_ac", ac, 7'h51);
    rd_chk(31); rd_chk(15);

    // 4: line gap wrap in both directions
    lcd_wr(0, 8'hA7); lcd_wr(1, 8'h78);
    chk("t4_ac_inc", ac, 7'h40);
    lcd_wr(0, 8'h04); lcd_wr(0, 8'h80); lcd_wr(1, 8'h5A);
    chk("t4_ac_dec", ac, 7'h67);
    rd_chk(0);
    lcd_wr(0, 8'hC0); lcd_wr(1, 8'h31);
    chk("t4_ac_dec40", ac, 7'h27);
    lcd_wr(0, 8'h02);
    // one-line wrap, plus no-op instructions
    lcd_wr(0, 8'h30); lcd_wr(0, 8'h06); lcd_wr(0, 8'hCF); lcd_wr(1, 8'h7A);
    chk("t4_ac_1line", ac, 7'h00);
    lcd_wr(0, 8'h40); lcd_wr(0, 8'h18); lcd_wr(0, 8'h00);
    lcd_wr(0, 8'h38);
    rd_all();

    // 5: fill, clear, then clear with a write dropped during busy
    lcd_wr(0, 8'h80);
    for (int i = 0; i < 16; i++) lcd_wr(1, 8'h61 + 8'(i));
    lcd_wr(0, 8'hC0);
    for (int i = 0; i < 16; i++) lcd_wr(1, 8'h41 + 8'(i));
    rd_all();
    lcd_wr(0, 8'h04);
    lcd_wr(0, 8'h01);
    chk("t5_incr", incr, 1);
    chk("t5_ovr0", ovr, 0);
    rd_all();
    lcd_wr(0, 8'h80); lcd_wr(1, 8'h2A); lcd_wr(1, 8'h2B);
    pulse(0, 0, 8'h01);
    m_reset(); m_two = 1;
    wait_busy(1, "t5_busy_to");
    repeat (20) @(negedge clk);
    pulse(1, 0, 8'h58);
    wait_busy(0, "t5_idle_to");
    @(negedge clk);
    chk("t5_ovr", ovr, 1);
    chk("t5_ac", ac, 0);
    rd_all();

    // 6: reset during clear
    lcd_wr(1, 8'h51);
    pulse(0, 0, 8'h01);
    wait_busy(1, "t6_busy_to");
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_ac", ac, 0);
    chk("t6_ovr", ovr, 0);
    chk("t6_init", init_done, 0);
    chk("t6_modes", {disp_on, cursor_on, blink_on, incr, two_line, frame_upd}, 6'b000100);
    chk("t6_rd_char", rd_char, 8'h20);
    rst = 1'b0;
    m_reset();
    rd_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
